// File: rtl/spart_pkg.sv
// Shared SPART constants: baud divisors for the 100 MHz system clock,
// the default rx oversampling exponent, and the divisor byte-write flags.
package spart_pkg;

  localparam int unsigned SYS_CLK_HZ  = 100_000_000;
  localparam int unsigned OS_LOG2_DEF = 4;

  // Divisor for a given bit rate: period is div+1 clocks, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned baud);
    return ((SYS_CLK_HZ + (baud / 2)) / baud) - 1;
  endfunction

  localparam logic [15:0] DIV_9600   = 16'(baud_div(9600));
  localparam logic [15:0] DIV_19200  = 16'(baud_div(19200));
  localparam logic [15:0] DIV_38400  = 16'(baud_div(38400));
  localparam logic [15:0] DIV_115200 = 16'(baud_div(115200));

  // Which divisor bytes have been written since reset.
  typedef struct packed {
    logic high;
    logic low;
  } wr_flags_t;

endpackage

// File: rtl/brg_reload_counter.sv
// Reloading down-counter producing a registered one-cycle tick.
// Ports: clk, rst (async, active-high), run (count enable), clear (force
// count to 0, highest priority), reload_val (value loaded at terminal count),
// resync (reload without ticking), tick (strobe the cycle after count==0).
module brg_reload_counter
  import spart_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         clear,
  input  logic [W-1:0] reload_val,
  input  logic         resync,
  output logic         tick
);

  logic [W-1:0] cnt;

  // Period is reload_val+1; decrement never wraps since reload happens at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      tick <= 1'b0;
    end else if (resync) begin
      cnt  <= reload_val;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= reload_val;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spart_brg_os.sv
// SPART baud rate generator with rx oversampling.
// Ports: clk, rst (async, active-high); enable (global run); load_low /
// load_high + data_in (divisor byte writes, high wins); rx_resync (receiver
// start-bit realign); tx_enable (bit-rate strobe); rx_enable (oversample
// strobe, divisor >> OS_LOG2); brg_ready (divisor valid, strobes permitted).
module spart_brg_os
  import spart_pkg::*;
#(
  parameter int unsigned      DIV_W        = 16,
  parameter int unsigned      OS_LOG2      = OS_LOG2_DEF,
  parameter logic [DIV_W-1:0] DEF_DIV      = DIV_W'(16'h028B),
  parameter bit               REQUIRE_LOAD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load_low,
  input  logic       load_high,
  input  logic [7:0] data_in,
  input  logic       rx_resync,
  output logic       tx_enable,
  output logic       rx_enable,
  output logic       brg_ready
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] rx_div;
  wr_flags_t        flags_q;
  wr_flags_t        flags_nxt;
  logic             ready_nxt;
  logic             clear_c;

  // Flag update, ready detection and counter restart on any write.
  always_comb begin
    flags_nxt = flags_q;
    if (load_high) begin
      flags_nxt.high = 1'b1;
    end else if (load_low) begin
      flags_nxt.low = 1'b1;
    end
    ready_nxt = brg_ready | (flags_nxt.high & flags_nxt.low) | ~REQUIRE_LOAD;
    // Counters sit at 0 until ready, and restart from 0 after every write.
    clear_c   = load_low | load_high | ~ready_nxt;
  end

  assign rx_div = div_q >> OS_LOG2;

  // Divisor bytes, write flags and sticky ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= DEF_DIV;
      flags_q   <= '0;
      brg_ready <= ~REQUIRE_LOAD;
    end else begin
      flags_q   <= flags_nxt;
      brg_ready <= ready_nxt;
      if (load_high) begin
        div_q[15:8] <= data_in;
      end else if (load_low) begin
        div_q[7:0] <= data_in;
      end
    end
  end

  brg_reload_counter #(.W(DIV_W)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .run        (enable),
    .clear      (clear_c),
    .reload_val (div_q),
    .resync     (1'b0),
    .tick       (tx_enable)
  );

  brg_reload_counter #(.W(DIV_W)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .run        (enable),
    .clear      (clear_c),
    .reload_val (rx_div),
    .resync     (rx_resync),
    .tick       (rx_enable)
  );

endmodule
